// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational extraction for RV32I/RV64I
// formats feeding a 2-entry skid buffer (output reg + skid reg) with valid/ready.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     Instr,
  input  logic [2:0]      ImmSrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ImmExt,
  output logic            out_illegal
);

  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  typedef struct packed {
    logic            ill;
    logic [XLEN-1:0] imm;
  } ent_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state_q, state_d;
  ent_t   or_q, sk_q, ent_in;
  logic   rdy_q;
  logic   accept, drain, ld_or, or_from_sk, ld_sk;

  // opcode bits never contribute to any immediate
  logic unused_opcode;
  assign unused_opcode = ^Instr[6:0];

  always_comb begin
    ent_in = '0;
    unique case (ImmSrc)
      3'b000: ent_in.imm = XLEN'($signed(Instr[31:20]));
      3'b001: ent_in.imm = XLEN'($signed({Instr[31:25], Instr[11:7]}));
      3'b010: ent_in.imm = XLEN'($signed({Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0}));
      3'b011: ent_in.imm = XLEN'($signed({Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0}));
      3'b100: ent_in.imm = XLEN'($signed({Instr[31:12], 12'b0}));
      3'b101: ent_in.imm = XLEN'(Instr[20 +: SHAMT_W]);
      3'b110: ent_in.imm = XLEN'(Instr[19:15]);
      default: ent_in.ill = 1'b1;
    endcase
  end

  assign in_ready    = rdy_q;
  assign out_valid   = (state_q != EMPTY);
  assign ImmExt      = or_q.imm;
  assign out_illegal = or_q.ill;

  assign accept = in_valid && rdy_q;
  assign drain  = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    ld_or      = 1'b0;
    or_from_sk = 1'b0;
    ld_sk      = 1'b0;
    unique case (state_q)
      EMPTY: if (accept) begin
        ld_or   = 1'b1;
        state_d = ONE;
      end
      ONE: begin
        if (accept && drain) ld_or = 1'b1;
        else if (accept) begin
          ld_sk   = 1'b1;
          state_d = FULL;
        end else if (drain) state_d = EMPTY;
      end
      FULL: if (drain) begin
        ld_or      = 1'b1;
        or_from_sk = 1'b1;
        state_d    = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is a flop decoded from next state, so out_ready never reaches it combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
      or_q    <= '0;
      sk_q    <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FULL);
      if (ld_or) or_q <= or_from_sk ? sk_q : ent_in;
      if (ld_sk) sk_q <= ent_in;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances on shared stimulus,
// checked against a field-arithmetic immediate model and a depth-2 FIFO model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] Instr;
  logic [2:0]  ImmSrc;
  logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) u32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .Instr(Instr), .ImmSrc(ImmSrc), .out_valid(vld32), .out_ready(out_ready),
    .ImmExt(imm32), .out_illegal(ill32));

  imm_gen_pipe #(.XLEN(64)) u64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .Instr(Instr), .ImmSrc(ImmSrc), .out_valid(vld64), .out_ready(out_ready),
    .ImmExt(imm64), .out_illegal(ill64));

  typedef struct {
    logic [63:0] e64;
    logic [31:0] e32;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   nerr = 0, nchk = 0, ndrain = 0;
  bit   zchk = 0, last_acc = 0;

  function automatic longint sext(longint x, int b);
    return x[b-1] ? x - (longint'(1) << b) : x;
  endfunction

  // Immediate built from the instruction-field definitions with integer arithmetic
  function automatic logic [63:0] ref_imm(logic [31:0] ins, logic [2:0] src, int xlen,
                                          output logic ill);
    longint u, v;
    u = longint'({32'b0, ins});
    ill = 1'b0;
    case (src)
      3'd0: v = sext((u >> 20) & 'hFFF, 12);
      3'd1: v = sext((((u >> 25) & 'h7F) << 5) | ((u >> 7) & 'h1F), 12);
      3'd2: v = sext((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                     (((u >> 25) & 'h3F) << 5) | (((u >> 8) & 'hF) << 1), 13);
      3'd3: v = sext((((u >> 31) & 1) << 20) | (((u >> 12) & 'hFF) << 12) |
                     (((u >> 20) & 1) << 11) | (((u >> 21) & 'h3FF) << 1), 21);
      3'd4: v = sext(u & 'hFFFFF000, 32);
      3'd5: v = (u >> 20) & ((xlen == 64) ? 'h3F : 'h1F);
      3'd6: v = (u >> 15) & 'h1F;
      default: begin v = 0; ill = 1'b1; end
    endcase
    if (xlen == 32) v = v & 'hFFFFFFFF;
    return 64'(v);
  endfunction

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk(64'(vld32), 64'(q.size() > 0), "out_valid32");
    chk(64'(vld64), 64'(q.size() > 0), "out_valid64");
    chk(64'(rdy32), 64'(q.size() < 2), "in_ready32");
    chk(64'(rdy64), 64'(q.size() < 2), "in_ready64");
    if (q.size() > 0) begin
      chk(64'(imm32), 64'(q[0].e32), "imm32");
      chk(imm64, q[0].e64, "imm64");
      chk(64'(ill32), 64'(q[0].ill), "illegal32");
      chk(64'(ill64), 64'(q[0].ill), "illegal64");
    end
    if (zchk) begin
      chk(64'(imm32), 64'd0, "reset_imm32");
      chk(imm64, 64'd0, "reset_imm64");
      chk(64'({ill32, ill64}), 64'd0, "reset_illegal");
      zchk = 0;
    end
  endtask

  task automatic model_update();
    bit   acc, drn;
    exp_t e;
    logic i32, i64;
    acc = in_valid && (q.size() < 2);
    drn = out_ready && (q.size() > 0);
    last_acc = 0;
    if (reset) begin
      q.delete();
      zchk = 1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (drn) begin void'(q.pop_front()); ndrain++; end
      if (acc) begin
        e.e64 = ref_imm(Instr, ImmSrc, 64, i64);
        e.e32 = ref_imm(Instr, ImmSrc, 32, i32)[31:0];
        e.ill = i32;
        q.push_back(e);
        last_acc = 1;
      end
    end
  endtask

  // sample at negedge, then advance model on the posedge; inputs change #1 after
  task automatic cyc();
    @(negedge clk);
    check_outs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic put(input logic [31:0] ins, input logic [2:0] src);
    Instr = ins; ImmSrc = src; in_valid = 1'b1;
  endtask

  logic [31:0] dv_ins [7] = '{32'hFFF00093, 32'hFE512E23, 32'h001000EF, 32'h123450B7,
                              32'h00000000, 32'h800000B7, 32'h03F0D093};
  logic [2:0]  dv_src [7] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd7, 3'd4, 3'd5};
  logic [31:0] dv_e32 [7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000800, 32'h12345000,
                              32'h0, 32'h80000000, 32'h0000001F};
  logic [63:0] dv_e64 [7] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h800,
                              64'h12345000, 64'h0, 64'hFFFFFFFF80000000, 64'h3F};

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Instr = '0; ImmSrc = '0;
    #1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // directed formats, each result visible right after the accepting edge
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      put(dv_ins[i], dv_src[i]);
      cyc();
      in_valid = 1'b0;
      chk(64'(vld32), 64'd1, "dir_valid");
      chk(64'(imm32), 64'(dv_e32[i]), "dir_imm32");
      chk(imm64, dv_e64[i], "dir_imm64");
      chk(64'(ill32), 64'(dv_src[i] == 3'd7), "dir_illegal");
      cyc();
    end

    // back-pressure: A to OR, B to SK, C held by source
    out_ready = 1'b0;
    put(32'hFFF00093, 3'd0); cyc();
    put(32'hFE512E23, 3'd1); cyc();
    put(32'h123450B7, 3'd4); cyc();
    chk(64'(rdy32), 64'd0, "bp_in_ready");
    cyc();
    out_ready = 1'b1;
    last_acc = 0;
    for (int k = 0; k < 8 && !last_acc; k++) cyc();
    chk(64'(last_acc), 64'd1, "bp_c_accepted");
    in_valid = 1'b0;
    cyc(); cyc(); cyc();

    // full throughput
    ndrain = 0;
    for (int i = 0; i < 16; i++) begin
      put($urandom, 3'($urandom_range(0, 7)));
      cyc();
    end
    in_valid = 1'b0;
    cyc(); cyc();
    chk(64'(ndrain), 64'd16, "tput_drains");

    // flush while FULL with a live input
    out_ready = 1'b0;
    put($urandom, 3'd0); cyc();
    put($urandom, 3'd2); cyc();
    put($urandom, 3'd3); flush = 1'b1; cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk(64'(vld32), 64'd0, "flush_valid");
    chk(64'(rdy64), 64'd1, "flush_in_ready");
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) cyc();

    // reset while FULL, out_ready toggling
    out_ready = 1'b0;
    put($urandom, 3'd1); cyc();
    out_ready = 1'b1;
    put($urandom, 3'd4); cyc();
    out_ready = 1'b0;
    put($urandom, 3'd5); cyc();
    out_ready = 1'b1; reset = 1'b1; cyc();
    reset = 1'b0; in_valid = 1'b0;
    chk(64'(vld64), 64'd0, "rst_valid");
    chk(64'(imm32), 64'd0, "rst_imm32");
    chk(64'(rdy32), 64'd1, "rst_in_ready");
    put(32'h001000EF, 3'd3); cyc();
    in_valid = 1'b0;
    cyc(); cyc(); cyc();

    // random soak with occasional flush
    for (int i = 0; i < 300; i++) begin
      Instr = $urandom; ImmSrc = 3'($urandom_range(0, 7));
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      cyc();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk(64'(q.size()), 64'd0, "final_empty");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
